weight_streamer: RTL
====================

# weight_streamer

Parametrised weight-row streamer for the forward-propagation datapath. It holds a weight matrix in an internal synchronous RAM that is loaded through a row-wide write port. On request it streams any contiguous run of rows, one row of LANES words per beat, over a valid/ready interface with backpressure. Between requests the data output reads zero. It replaces the fixed two-layer weight source: one instance is placed per layer, for example LANES=128/DEPTH=784 for layer 0 and LANES=10/DEPTH=128 for layer 1.

## Interface
- DATA_W, 32, width of one weight word
- LANES, 128, words per row (one beat)
- DEPTH, 784, rows stored; must be ≥ 2
- ADDR_W, $clog2(DEPTH), row address width
- clka  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  write one row this cycle
- wr_addr  in  ADDR_W  row written
- wr_data  in  LANES×DATA_W  row contents
- start  in  1  request pulse, sampled every cycle
- start_base  in  ADDR_W  first row of the request
- start_rows  in  ADDR_W+1  row count, 1..DEPTH
- abort  in  1  cancel the current request
- busy  out  1  request in progress
- start_err  out  1  one-cycle pulse: start was rejected
- out_valid  out  1  out_data holds a row
- out_ready  in  1  consumer accepts the row
- out_data  out  LANES×DATA_W  row data; all zero when out_valid=0
- out_last  out  1  final row of the request, qualified by out_valid
- done  out  1  one-cycle pulse after the last row is accepted

## Operation
- States: IDLE and RUN.
- IDLE → RUN on start when start_rows is in 1..DEPTH and start_base < DEPTH. The block latches rd_ptr=start_base and rd_left=start_rows and sets busy=1.
- If start arrives with an out-of-range field, or while busy=1, the request is ignored and start_err pulses in the next cycle.
- In RUN, a read is issued when rd_left>0 and occupancy+inflight<2. Occupancy counts rows held in the 2-entry output buffer; inflight counts RAM reads issued but not yet returned.
  - Each read increments rd_ptr, wrapping from DEPTH-1 to 0, and decrements rd_left.
- The output buffer is a 2-entry FIFO. The row at its head drives out_data. A beat transfers when out_valid && out_ready.
- out_last is 1 on the beat that carries the start_rows-th row.
- When the out_last beat transfers, the block returns to IDLE: busy=0 and done=1 in the next cycle.
- abort while in RUN: the buffer is flushed, any inflight return is discarded, rd_left is cleared and the block enters IDLE. From the next cycle out_valid=0, busy=0 and done=0. abort while in IDLE has no effect. If start and abort are asserted in the same cycle, abort wins and start_err pulses.
- Writes are accepted in any state.
  - If a read and a write hit the same address in the same cycle, the read returns the old data.
  - Rows already read are not updated by later writes.
- Reset: all outputs 0, state IDLE, pointers and counters 0. RAM contents are undefined after reset; a test build may preload them with a constant.

## Timing
- Start is sampled at edge N. The first RAM read is issued in cycle N+1 and its data is registered at N+2. out_valid therefore first rises after edge N+2, giving a start-to-first-beat latency of 2 cycles.
- With out_ready held at 1, one row transfers per cycle. A request of R rows finishes its last beat R+1 cycles after the start edge, and done follows one cycle later.
- out_ready is allowed to drop at any time without losing a row. The 2-entry buffer plus the credit rule make overflow impossible.
- A new start is accepted in the same cycle that done is high.

## Structure
- Package weight_pkg holds:
  - the DATA_W and LANES defaults;
  - the row_t typedef (LANES×DATA_W packed);
  - the state enum ws_state_e {WS_IDLE, WS_RUN}.
- Sub-module ws_row_ram is a single-port-read, single-port-write synchronous RAM, DEPTH×row_t, with 1-cycle read latency and read-old-on-collision behaviour. It is the only storage to be mapped to BRAM.
- The output FIFO and the control FSM stay in weight_streamer.

## Test plan
- Load row r with every lane set to r+1 (DEPTH=784, LANES=128). Start base=0, rows=784, out_ready=1 → out_valid first rises 2 cycles after start. Beat k has every lane equal to k+1. out_last is set only on beat 784. done pulses the next cycle, then out_data=0.
- Start base=780, rows=8 → data sequence is rows 780..783 then 0..3 (wrap-around). out_last is set on the 8th beat.
- Drive out_ready with a random 50% duty cycle for rows=128 → all 128 rows arrive in order with no duplicates or drops. out_valid never falls without a transfer having occurred.
- Start while busy, and start with rows=0 or rows=785 → start_err pulses once for each. The running stream is unaffected and the busy and state values do not change.
- With out_ready=0, abort mid-request after two rows are buffered → out_valid=0, busy=0 and out_data=0 the next cycle. A following start with base=5, rows=1 delivers row 5 correctly.
- Assert rst mid-stream → all outputs are 0 immediately (asynchronously). After release, a fresh start streams correctly.

Source files
------------

// File: rtl/weight_pkg.sv
// Shared types and defaults for the weight-row streamer and its row RAM.
package weight_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int LANES_DEF  = 128;

    typedef logic [LANES_DEF*DATA_W_DEF-1:0] row_t;

    typedef enum logic {WS_IDLE, WS_RUN} ws_state_e;
endpackage

// File: rtl/ws_row_ram.sv
// Row-wide synchronous RAM: one write port, one read port, 1-cycle read latency.
// A read and write to the same row in one cycle return the previous contents.
module ws_row_ram
    import weight_pkg::*;
#(
    parameter int ROW_W  = DATA_W_DEF * LANES_DEF,
    parameter int DEPTH  = 784,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clka,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ROW_W-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ROW_W-1:0]  rd_data
);
    logic [ROW_W-1:0] mem [DEPTH];

    always_ff @(posedge clka) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/weight_streamer.sv
// Streams a contiguous (wrapping) run of weight rows from internal RAM over
// a valid/ready interface, buffered by a 2-entry output FIFO.
module weight_streamer
    import weight_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int DEPTH  = 784,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                    clka,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [LANES*DATA_W-1:0] wr_data,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       start_base,
    input  logic [ADDR_W:0]         start_rows,
    input  logic                    abort,
    output logic                    busy,
    output logic                    start_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*DATA_W-1:0] out_data,
    output logic                    out_last,
    output logic                    done
);
    localparam int ROW_W = LANES * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);

    ws_state_e         state_reg;
    logic              busy_reg, start_err_reg, done_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   rd_left_reg;
    logic              inflight_reg, inflight_last_reg;
    logic [1:0]        count_reg, count_next;
    logic              head_reg, tail_reg;
    logic [1:0]        last_flag_reg;
    logic [ROW_W-1:0]  ram_q, head_data;
    logic              start_ok, accept, pop, rd_en;
    logic [2:0]        occ_sum;

    ws_row_ram #(.ROW_W(ROW_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clka    (clka),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_reg),
        .rd_data (ram_q)
    );

    assign start_ok = (start_rows != '0) && (start_rows <= DEPTH_W)
                   && ({1'b0, start_base} < DEPTH_W);
    assign accept   = start && !abort && (state_reg == WS_IDLE) && start_ok;
    assign pop      = (count_reg != 2'd0) && out_ready;
    // A row leaving this cycle frees its slot, keeping one beat per cycle.
    assign occ_sum  = {1'b0, count_reg} + {2'b0, inflight_reg} - {2'b0, pop};
    assign rd_en    = (state_reg == WS_RUN) && !abort && (rd_left_reg != '0)
                   && (occ_sum < 3'd2);
    assign count_next = count_reg + {1'b0, inflight_reg} - {1'b0, pop};

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_reg         <= WS_IDLE;
            busy_reg          <= 1'b0;
            start_err_reg     <= 1'b0;
            done_reg          <= 1'b0;
            rd_ptr_reg        <= '0;
            rd_left_reg       <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            count_reg         <= '0;
            head_reg          <= 1'b0;
            tail_reg          <= 1'b0;
            last_flag_reg     <= '0;
        end else begin
            start_err_reg <= start && !accept;
            done_reg      <= 1'b0;
            case (state_reg)
                WS_IDLE: begin
                    if (accept) begin
                        state_reg   <= WS_RUN;
                        busy_reg    <= 1'b1;
                        rd_ptr_reg  <= start_base;
                        rd_left_reg <= start_rows;
                    end
                end
                WS_RUN: begin
                    if (abort) begin
                        state_reg         <= WS_IDLE;
                        busy_reg          <= 1'b0;
                        rd_left_reg       <= '0;
                        inflight_reg      <= 1'b0;
                        inflight_last_reg <= 1'b0;
                        count_reg         <= '0;
                        head_reg          <= 1'b0;
                        tail_reg          <= 1'b0;
                    end else begin
                        if (rd_en) begin
                            rd_ptr_reg  <= (rd_ptr_reg == LAST_ROW) ? '0 : rd_ptr_reg + ADDR_W'(1);
                            rd_left_reg <= rd_left_reg - (ADDR_W+1)'(1);
                        end
                        inflight_reg      <= rd_en;
                        inflight_last_reg <= rd_en && (rd_left_reg == (ADDR_W+1)'(1));
                        if (inflight_reg) begin
                            last_flag_reg[tail_reg] <= inflight_last_reg;
                            tail_reg                <= ~tail_reg;
                        end
                        if (pop)
                            head_reg <= ~head_reg;
                        count_reg <= count_next;
                        if (pop && last_flag_reg[head_reg]) begin
                            state_reg <= WS_IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end
                    end
                end
                default: state_reg <= WS_IDLE;
            endcase
        end
    end

    // Row payload registers carry no reset; validity is tracked by count_reg.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [ROW_W-1:0] data_reg;
        always_ff @(posedge clka) begin
            if (inflight_reg && (tail_reg == 1'(gi)))
                data_reg <= ram_q;
        end
    end

    assign head_data = head_reg ? g_fifo[1].data_reg : g_fifo[0].data_reg;
    assign out_valid = (count_reg != 2'd0);
    assign out_data  = out_valid ? head_data : '0;
    assign out_last  = out_valid && last_flag_reg[head_reg];
    assign busy      = busy_reg;
    assign start_err = start_err_reg;
    assign done      = done_reg;
endmodule
